dsp_mult_arbiter: RTL and testbench

DSP_MULT_ARBITER -- requirements
Module: dsp_mult_arbiter

---
 rtl/apu_cluster_package.sv | 18 +
 rtl/dsp_mult_arbiter_if.sv | 29 ++
 rtl/dsp_mult_rr_arb.sv | 32 +++
 rtl/dsp_mult_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dsp_mult_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apu_cluster_package.sv
// apu_cluster_package: shared DSP datapath widths and the multiplier request
// payload used by the dot-product multiplier arbiter.
package apu_cluster_package;

    localparam int unsigned DSP_WIDTH            = 32;
    localparam int unsigned DSP_OP_WIDTH         = 2;
    localparam int unsigned DSP_MULT_ARB_NUM_REQ = 4;

    // One requester's operation as presented to the shared multiplier
    typedef struct packed {
        logic [DSP_OP_WIDTH-1:0] op;
        logic [DSP_WIDTH-1:0]    opa;
        logic [DSP_WIDTH-1:0]    opb;
        logic [DSP_WIDTH-1:0]    opc;
        logic [1:0]              flag;
    } dsp_mult_req_t;

endpackage

// File: rtl/dsp_mult_arbiter_if.sv
// dsp_mult_arbiter_if: unit-side bus between the arbiter and the shared
// multiplier wrapper. Issue fields (En/Op/OpA/OpB/OpC/Flag/Tag) flow from
// master to slave; the tagged result (Res/Tag/Valid) flows back.
interface dsp_mult_arbiter_if #(
    parameter int unsigned TAG_WIDTH = 2
) ();

    logic                                         en;
    logic [apu_cluster_package::DSP_OP_WIDTH-1:0] op;
    logic [apu_cluster_package::DSP_WIDTH-1:0]    opa;
    logic [apu_cluster_package::DSP_WIDTH-1:0]    opb;
    logic [apu_cluster_package::DSP_WIDTH-1:0]    opc;
    logic [1:0]                                   flag;
    logic [TAG_WIDTH-1:0]                         tag;
    logic [apu_cluster_package::DSP_WIDTH-1:0]    res;
    logic [TAG_WIDTH-1:0]                         res_tag;
    logic                                         valid;

    modport master (
        output en, op, opa, opb, opc, flag, tag,
        input  res, res_tag, valid
    );

    modport slave (
        input  en, op, opa, opb, opc, flag, tag,
        output res, res_tag, valid
    );

endinterface

// File: rtl/dsp_mult_rr_arb.sv
// dsp_mult_rr_arb: round-robin priority pick. Scans from ptr upward, wrapping
// at NUM_REQ-1, and grants the first eligible requester (one-hot or zero).
module dsp_mult_rr_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    int unsigned idx;
    logic        found;

    // First eligible requester at or after ptr wins
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && eligible_i[PTR_W'(idx)]) begin
                gnt_o[PTR_W'(idx)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_mult_arbiter.sv
// dsp_mult_arbiter: shares one dot-product multiplier among NUM_REQ requesters.
// Grants are combinational round-robin; results return tagged with the
// requester index and are parked in a per-requester slot until read.
// Optional feature: define DSP_MULT_ARB_PERF_CNT_EN to build the saturating
// issue/stall performance counters (otherwise the perf ports read zero).
module dsp_mult_arbiter
    import apu_cluster_package::*;
#(
    parameter int unsigned NUM_REQ   = DSP_MULT_ARB_NUM_REQ,
    parameter int unsigned PIPE_REGS = 1,
    parameter int unsigned TAG_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_i,
    output logic [NUM_REQ-1:0]                   gnt_o,
    input  logic [NUM_REQ-1:0][DSP_OP_WIDTH-1:0] op_i,
    input  logic [NUM_REQ-1:0][DSP_WIDTH-1:0]    opa_i,
    input  logic [NUM_REQ-1:0][DSP_WIDTH-1:0]    opb_i,
    input  logic [NUM_REQ-1:0][DSP_WIDTH-1:0]    opc_i,
    input  logic [NUM_REQ-1:0][1:0]              flag_i,
    output logic [NUM_REQ-1:0]                   rvalid_o,
    output logic [NUM_REQ-1:0][DSP_WIDTH-1:0]    rdata_o,
    input  logic [NUM_REQ-1:0]                   rready_i,
    dsp_mult_arbiter_if.master                   unit,
    output logic                                 err_o,
    output logic [31:0]                          perf_issue_o,
    output logic [31:0]                          perf_stall_o
);

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned FLUSH_W = $clog2(PIPE_REGS + 2);

    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [NUM_REQ-1:0]              pending_q, pending_d;
    logic [NUM_REQ-1:0]              rvalid_q, rvalid_d;
    logic [NUM_REQ-1:0][DSP_WIDTH-1:0] slot_q, slot_d;
    logic                            err_q, err_d;
    logic [FLUSH_W-1:0]              flush_q, flush_d;

    logic [NUM_REQ-1:0]              eligible;
    logic [NUM_REQ-1:0]              gnt;
    logic [NUM_REQ-1:0]              hs;
    logic [NUM_REQ-1:0]              in_flight;
    logic [NUM_REQ-1:0]              store;
    logic                            valid_live;
    logic [PTR_W-1:0]                gnt_idx;
    dsp_mult_req_t                   sel;

    // Nobody is eligible while in reset or while its previous op is outstanding
    assign eligible = rst_i ? '0 : (req_i & ~pending_q);

    dsp_mult_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arb (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .gnt_o      (gnt)
    );

    // Encode the winner and route its operands to the unit (zero when idle)
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[PTR_W'(i)]) begin
                gnt_idx = PTR_W'(i);
            end
        end
        sel = '0;
        if (|gnt) begin
            sel.op   = op_i[gnt_idx];
            sel.opa  = opa_i[gnt_idx];
            sel.opb  = opb_i[gnt_idx];
            sel.opc  = opc_i[gnt_idx];
            sel.flag = flag_i[gnt_idx];
        end
    end

    assign gnt_o     = gnt;
    assign unit.en   = |gnt;
    assign unit.op   = sel.op;
    assign unit.opa  = sel.opa;
    assign unit.opb  = sel.opb;
    assign unit.opc  = sel.opc;
    assign unit.flag = sel.flag;
    assign unit.tag  = (|gnt) ? TAG_WIDTH'(gnt_idx) : '0;

    // Classify a returning result: store it if its slot expects one, else flag an error
    always_comb begin
        in_flight = pending_q;
        if (PIPE_REGS == 0) begin
            in_flight = pending_q | gnt;
        end
        valid_live = unit.valid && (flush_q == '0);
        store      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (valid_live && (32'(unit.res_tag) == i) &&
                in_flight[PTR_W'(i)] && !rvalid_q[PTR_W'(i)]) begin
                store[PTR_W'(i)] = 1'b1;
            end
        end
    end

    // Next-state for pointer, pending/rvalid bookkeeping, slots, error and flush window
    always_comb begin
        hs        = rvalid_q & rready_i;
        pending_d = (pending_q & ~hs) | gnt;
        rvalid_d  = (rvalid_q & ~hs) | store;
        slot_d    = slot_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (store[PTR_W'(i)]) begin
                slot_d[PTR_W'(i)] = unit.res;
            end
        end
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(gnt_idx + PTR_W'(1));
        end
        err_d   = err_q | (valid_live && (store == '0));
        flush_d = (flush_q != '0) ? FLUSH_W'(flush_q - FLUSH_W'(1)) : flush_q;
    end

    // State registers; reset reopens the flush window to swallow an interrupted op
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            pending_q <= '0;
            rvalid_q  <= '0;
            slot_q    <= '0;
            err_q     <= 1'b0;
            flush_q   <= FLUSH_W'(PIPE_REGS);
        end else begin
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            rvalid_q  <= rvalid_d;
            slot_q    <= slot_d;
            err_q     <= err_d;
            flush_q   <= flush_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = slot_q;
    assign err_o    = err_q;

`ifdef DSP_MULT_ARB_PERF_CNT_EN
    logic [31:0] issue_q, issue_d;
    logic [31:0] stall_q, stall_d;

    // Saturating counts of grant cycles and of requested-but-idle cycles
    always_comb begin
        issue_d = issue_q;
        stall_d = stall_q;
        if ((|gnt) && (issue_q != '1)) begin
            issue_d = issue_q + 32'd1;
        end
        if ((|req_i) && !(|gnt) && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_q <= '0;
            stall_q <= '0;
        end else begin
            issue_q <= issue_d;
            stall_q <= stall_d;
        end
    end

    assign perf_issue_o = issue_q;
    assign perf_stall_o = stall_q;
`else
    assign perf_issue_o = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_dsp_mult_arbiter.sv
// tb_dsp_mult_arbiter: table-driven, directed and random checking of the
// multiplier arbiter against a cycle-level behavioural reference model.
module tb_dsp_mult_arbiter;
    import apu_cluster_package::*;

    localparam int unsigned N    = DSP_MULT_ARB_NUM_REQ;
    localparam int unsigned PIPE = 1;
    localparam int unsigned TW   = $clog2(N);

    logic                           clk_i = 1'b0;
    logic                           rst_i;
    logic [N-1:0]                   req_i, gnt_o, rvalid_o, rready_i;
    logic [N-1:0][DSP_OP_WIDTH-1:0] op_i;
    logic [N-1:0][DSP_WIDTH-1:0]    opa_i, opb_i, opc_i, rdata_o;
    logic [N-1:0][1:0]              flag_i;
    logic                           err_o;
    logic [31:0]                    perf_issue_o, perf_stall_o;

    dsp_mult_arbiter_if #(.TAG_WIDTH(TW)) unit_if ();

    dsp_mult_arbiter #(
        .NUM_REQ   (N),
        .PIPE_REGS (PIPE),
        .TAG_WIDTH (TW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .op_i         (op_i),
        .opa_i        (opa_i),
        .opb_i        (opb_i),
        .opc_i        (opc_i),
        .flag_i       (flag_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .rready_i     (rready_i),
        .unit         (unit_if),
        .err_o        (err_o),
        .perf_issue_o (perf_issue_o),
        .perf_stall_o (perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int                   due;
        int                   tag;
        logic [DSP_WIDTH-1:0] res;
    } flight_t;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] rdy;
        logic [N-1:0] gnt;
        logic [N-1:0] rv;
    } vec_t;

    // Reference model state
    bit                   m_pend [N];
    bit                   m_rv   [N];
    logic [DSP_WIDTH-1:0] m_slot [N];
    int                   m_ptr;
    bit                   m_err;
    int                   m_flush;
    longint               m_issue, m_stall;
    flight_t              flights[$];

    int n_checks, n_fail, cyc;
    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_pend[i] = 0;
            m_rv[i]   = 0;
            m_slot[i] = '0;
        end
        m_ptr   = 0;
        m_err   = 0;
        m_flush = int'(PIPE);
        m_issue = 0;
        m_stall = 0;
    endtask

    // One clock cycle: drive inputs and the multiplier's return, check every output
    // against the model, then advance the model across the coming edge.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] rdy, input logic rst,
                        input bit stray, input int stray_tag);
        int                   g;
        bit                   v, acc;
        int                   vt;
        logic [DSP_WIDTH-1:0] vr;
        flight_t              f;
        logic [N-1:0]         exp_gnt, exp_rv;
        bit                   hs [N];
        @(negedge clk_i);
        rst_i    = rst;
        req_i    = req;
        rready_i = rdy;
        v = 0; acc = 0; vt = 0; vr = '0;
        if (flights.size() > 0 && flights[0].due == cyc) begin
            f  = flights.pop_front();
            v  = 1;
            vt = f.tag;
            vr = f.res;
        end else if (stray) begin
            v  = 1;
            vt = stray_tag;
            vr = DSP_WIDTH'($urandom);
        end
        unit_if.valid   = v;
        unit_if.res_tag = TW'(vt);
        unit_if.res     = vr;
        #1;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < int'(N); k++) begin
                int idx;
                idx = (m_ptr + k) % int'(N);
                if (g < 0 && req[idx] && !m_pend[idx]) g = idx;
            end
        end
        exp_gnt = (g >= 0) ? N'(1 << g) : '0;
        for (int i = 0; i < int'(N); i++) exp_rv[i] = m_rv[i];
        check("gnt_o", 64'(gnt_o), 64'(exp_gnt));
        check("En_o", 64'(unit_if.en), (g >= 0) ? 64'd1 : 64'd0);
        check("Tag_o", 64'(unit_if.tag), (g >= 0) ? 64'(g) : 64'd0);
        check("Op_o", 64'(unit_if.op), (g >= 0) ? 64'(op_i[g]) : 64'd0);
        check("OpA_o", 64'(unit_if.opa), (g >= 0) ? 64'(opa_i[g]) : 64'd0);
        check("OpB_o", 64'(unit_if.opb), (g >= 0) ? 64'(opb_i[g]) : 64'd0);
        check("OpC_o", 64'(unit_if.opc), (g >= 0) ? 64'(opc_i[g]) : 64'd0);
        check("Flag_o", 64'(unit_if.flag), (g >= 0) ? 64'(flag_i[g]) : 64'd0);
        check("rvalid_o", 64'(rvalid_o), 64'(exp_rv));
        for (int i = 0; i < int'(N); i++)
            check($sformatf("rdata_o[%0d]", i), 64'(rdata_o[i]), 64'(m_slot[i]));
        check("err_o", 64'(err_o), 64'(m_err));
`ifdef DSP_MULT_ARB_PERF_CNT_EN
        check("perf_issue_o", 64'(perf_issue_o), 64'(m_issue));
        check("perf_stall_o", 64'(perf_stall_o), 64'(m_stall));
`else
        check("perf_issue_o", 64'(perf_issue_o), 64'd0);
        check("perf_stall_o", 64'(perf_stall_o), 64'd0);
`endif
        // The multiplier itself is not reset: a granted op always comes back PIPE cycles later
        if (g >= 0) begin
            f.due = cyc + int'(PIPE);
            f.tag = g;
            f.res = DSP_WIDTH'(opa_i[g] * opb_i[g] + opc_i[g]);
            flights.push_back(f);
        end
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < int'(N); i++) hs[i] = m_rv[i] && rdy[i];
            if (v && m_flush == 0) begin
                if (vt < int'(N) && m_pend[vt] && !m_rv[vt]) begin
                    m_slot[vt] = vr;
                    acc = 1;
                end else begin
                    m_err = 1;
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (hs[i]) begin
                    m_rv[i]   = 0;
                    m_pend[i] = 0;
                end
            end
            if (acc) m_rv[vt] = 1;
            if (g >= 0) begin
                m_pend[g] = 1;
                m_ptr     = (g + 1) % int'(N);
                m_issue++;
            end else if (req != '0) begin
                m_stall++;
            end
            if (m_flush > 0) m_flush--;
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_i    = 1'b1;
        req_i    = '0;
        rready_i = '0;
        op_i     = '0;
        opa_i    = '0;
        opb_i    = '0;
        opc_i    = '0;
        flag_i   = '0;
        unit_if.valid   = 1'b0;
        unit_if.res     = '0;
        unit_if.res_tag = '0;
        model_reset();
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < int'(N); i++) begin
            op_i[i]   = DSP_OP_WIDTH'(i);
            opa_i[i]  = DSP_WIDTH'(10 + i);
            opb_i[i]  = DSP_WIDTH'(20 + i);
            opc_i[i]  = DSP_WIDTH'(i);
            flag_i[i] = 2'(i);
        end

        // Reset state, then all four requesting with results drained immediately
        tbl[0] = '{4'b1111, 4'b1111, 4'b0001, 4'b0000};
        tbl[1] = '{4'b1111, 4'b1111, 4'b0010, 4'b0000};
        tbl[2] = '{4'b1111, 4'b1111, 4'b0100, 4'b0001};
        tbl[3] = '{4'b1111, 4'b1111, 4'b1000, 4'b0010};
        tbl[4] = '{4'b1111, 4'b1111, 4'b0001, 4'b0100};
        step('0, '0, 1'b1, 1'b0, 0);
        check("reset_rvalid", 64'(rvalid_o), 64'd0);
        check("reset_err", 64'(err_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].req, tbl[i].rdy, 1'b0, 1'b0, 0);
            check($sformatf("tbl_gnt[%0d]", i), 64'(gnt_o), 64'(tbl[i].gnt));
            check($sformatf("tbl_rvalid[%0d]", i), 64'(rvalid_o), 64'(tbl[i].rv));
        end
        check("tbl_err", 64'(err_o), 64'd0);
        repeat (6) step('0, '1, 1'b0, 1'b0, 0);

        // Requester 2 holds an unread dot-product result for 10 cycles
        step('0, '0, 1'b1, 1'b0, 0);
        op_i[2]  = 2'd1;
        opa_i[2] = 32'd3;
        opb_i[2] = 32'd5;
        opc_i[2] = 32'd0;
        step(4'b0100, '0, 1'b0, 1'b0, 0);
        check("r2_grant", 64'(gnt_o), 64'b0100);
        check("r2_opa", 64'(unit_if.opa), 64'd3);
        step(4'b0100, '0, 1'b0, 1'b0, 0);
        check("r2_rvalid_c1", 64'(rvalid_o[2]), 64'd0);
        for (int i = 0; i < 10; i++) begin
            step(4'b0100, '0, 1'b0, 1'b0, 0);
            check("r2_rvalid_hold", 64'(rvalid_o[2]), 64'd1);
            check("r2_rdata_hold", 64'(rdata_o[2]), 64'd15);
            check("r2_no_regrant", 64'(gnt_o[2]), 64'd0);
        end
        step('0, 4'b0100, 1'b0, 1'b0, 0);
        step('0, '0, 1'b0, 1'b0, 0);
        check("r2_rvalid_clr", 64'(rvalid_o[2]), 64'd0);

        // Grant to 1 in the same cycle as the return for 3
        step('0, '0, 1'b1, 1'b0, 0);
        step(4'b1000, '0, 1'b0, 1'b0, 0);
        check("r3_grant", 64'(gnt_o), 64'b1000);
        step(4'b0010, '0, 1'b0, 1'b0, 0);
        check("r1_grant_with_ret", 64'(gnt_o), 64'b0010);
        step(4'b0010, '0, 1'b0, 1'b0, 0);
        check("r3_rvalid", 64'(rvalid_o), 64'b1000);
        check("r1_pending", 64'(gnt_o[1]), 64'd0);
        repeat (4) step('0, '1, 1'b0, 1'b0, 0);

        // Stray return: ignored in the flush window, an error afterwards
        step('0, '0, 1'b1, 1'b0, 0);
        step('0, '0, 1'b0, 1'b1, 0);
        step('0, '0, 1'b0, 1'b0, 0);
        check("flush_no_err", 64'(err_o), 64'd0);
        check("flush_no_store", 64'(rvalid_o), 64'd0);
        step('0, '0, 1'b0, 1'b1, 0);
        step('0, '0, 1'b0, 1'b0, 0);
        check("stray_err", 64'(err_o), 64'd1);
        check("stray_no_rvalid", 64'(rvalid_o), 64'd0);
        repeat (3) step(4'b0001, '1, 1'b0, 1'b0, 0);
        check("err_sticky", 64'(err_o), 64'd1);
        repeat (3) step('0, '1, 1'b0, 1'b0, 0);

        // Reset pulse while requester 0 is in flight
        step('0, '0, 1'b1, 1'b0, 0);
        step(4'b0001, '0, 1'b0, 1'b0, 0);
        check("inflight_grant", 64'(gnt_o), 64'b0001);
        step('0, '0, 1'b1, 1'b0, 0);
        step('0, '0, 1'b0, 1'b0, 0);
        check("rst_drop_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_drop_err", 64'(err_o), 64'd0);
        step(4'b1111, '0, 1'b0, 1'b0, 0);
        check("rst_ptr0", 64'(gnt_o), 64'b0001);
        repeat (6) step('0, '1, 1'b0, 1'b0, 0);

        // Three grants then two fully stalled cycles
        step('0, '0, 1'b1, 1'b0, 0);
        repeat (5) step(4'b0111, '0, 1'b0, 1'b0, 0);
        step('0, '0, 1'b0, 1'b0, 0);
`ifdef DSP_MULT_ARB_PERF_CNT_EN
        check("perf_issue_3", 64'(perf_issue_o), 64'd3);
        check("perf_stall_2", 64'(perf_stall_o), 64'd2);
`else
        check("perf_issue_off", 64'(perf_issue_o), 64'd0);
        check("perf_stall_off", 64'(perf_stall_o), 64'd0);
`endif
        repeat (6) step('0, '1, 1'b0, 1'b0, 0);

        // Random traffic, occasional resets and stray returns
        step('0, '0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < int'(N); r++) begin
                op_i[r]   = DSP_OP_WIDTH'($urandom);
                opa_i[r]  = DSP_WIDTH'($urandom);
                opb_i[r]  = DSP_WIDTH'($urandom);
                opc_i[r]  = DSP_WIDTH'($urandom);
                flag_i[r] = 2'($urandom);
            end
            step(N'($urandom), N'($urandom), $urandom_range(0, 63) == 0,
                 $urandom_range(0, 31) == 0, int'($urandom_range(0, N - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
